// File: rtl/apb_master.sv
// APB master: turns single cmd/rsp requests into one APB SETUP/ACCESS transfer at a time.
// Optional macro APB_MASTER_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait cycles.
module apb_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
   output logic                    rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pready_i,
   input  logic                    pslverr_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state_r;
   logic   cmd_ready_r;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_WIDTH-1:0] tmo_cnt_r;
   logic                 tmo_hit_s;
   assign tmo_hit_s = (tmo_cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

   // The ready register is forced low while reset is applied so no command slips in.
   assign cmd_ready_o = cmd_ready_r & ~rst_i;

   // Transfer sequencer; all bus and response outputs are registered here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= IDLE;
         cmd_ready_r <= 1'b1;
         psel_o      <= 1'b0;
         penable_o   <= 1'b0;
         pwrite_o    <= 1'b0;
         paddr_o     <= '0;
         pwdata_o    <= '0;
         pstrb_o     <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         tmo_cnt_r   <= '0;
`endif
      end else begin
         rsp_valid_o <= 1'b0;
         case (state_r)
            IDLE: begin
               // The response cycle leaves ready low, so acceptance waits one more cycle.
               if (cmd_valid_i && cmd_ready_r) begin
                  paddr_o     <= cmd_addr_i;
                  pwrite_o    <= cmd_write_i;
                  pwdata_o    <= cmd_wdata_i;
                  pstrb_o     <= cmd_write_i ? cmd_strb_i : '0;
                  psel_o      <= 1'b1;
                  penable_o   <= 1'b0;
                  cmd_ready_r <= 1'b0;
                  state_r     <= SETUP;
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            SETUP: begin
               penable_o <= 1'b1;
               state_r   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
               tmo_cnt_r <= '0;
`endif
            end
            ACCESS: begin
               if (pready_i) begin
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= pslverr_i;
                  rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                  state_r     <= IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
               end else if (tmo_hit_s) begin
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  rsp_rdata_o <= '0;
                  state_r     <= IDLE;
               end else begin
                  tmo_cnt_r   <= tmo_cnt_r + CNT_WIDTH'(1);
`else
               end else begin
                  state_r     <= ACCESS;
`endif
               end
            end
            default: begin
               psel_o      <= 1'b0;
               penable_o   <= 1'b0;
               cmd_ready_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a bench-side APB slave model serves each transfer,
// expected responses are queued at the command handshake and compared on rsp_valid_o.
module tb_apb_master;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [3:0]  cmd_strb_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic [3:0]  pstrb_o;
   logic [31:0] prdata_i;
   logic        pready_i;
   logic        pslverr_i;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          lat;
      int          acc;
      int          hs;
   } txn_t;

   txn_t         exp_q[$];
   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc = 0;
   int           last_rsp_cyc = 0;
   int           access_cnt = 0;
   int           wait_cnt = 0;
   logic [127:0] snap;

   apb_master #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (32),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write_i),
      .cmd_addr_i (cmd_addr_i),
      .cmd_wdata_i(cmd_wdata_i),
      .cmd_strb_i (cmd_strb_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o  (rsp_err_o),
      .psel_o     (psel_o),
      .penable_o  (penable_o),
      .pwrite_o   (pwrite_o),
      .paddr_o    (paddr_o),
      .pwdata_o   (pwdata_o),
      .pstrb_o    (pstrb_o),
      .prdata_i   (prdata_i),
      .pready_i   (pready_i),
      .pslverr_i  (pslverr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Slave model: inserts the queued number of wait states, then answers.
   always @(negedge clk) begin
      if (psel_o && penable_o && exp_q.size() > 0) begin
         if (wait_cnt < exp_q[0].waits) begin
            pready_i = 1'b0;
            wait_cnt++;
         end else begin
            pready_i  = 1'b1;
            prdata_i  = exp_q[0].rdata;
            pslverr_i = exp_q[0].err;
         end
      end else begin
         pready_i  = 1'b0;
         pslverr_i = 1'b0;
         prdata_i  = $urandom;
         wait_cnt  = 0;
      end
   end

   // Bus monitor and scoreboard compare.
   always @(negedge clk) begin
      if (psel_o && !penable_o) begin
         access_cnt = 0;
         snap = {59'd0, cmd_ready_o, pwrite_o, paddr_o, pwdata_o, pstrb_o};
         if (exp_q.size() == 0) begin
            check("unexpected_setup", 1, 0);
         end else begin
            check("setup_cycle", cyc, exp_q[0].hs + 1);
            check("setup_bus", snap,
                  {59'd0, 1'b0, exp_q[0].wr, exp_q[0].addr, pwdata_o,
                   exp_q[0].wr ? exp_q[0].strb : 4'h0});
            if (exp_q[0].wr) check("setup_wdata", pwdata_o, exp_q[0].wdata);
         end
      end else if (psel_o && penable_o) begin
         access_cnt++;
         check("access_stable", {59'd0, cmd_ready_o, pwrite_o, paddr_o, pwdata_o, pstrb_o},
               {59'd0, 1'b0, snap[68:0]});
      end
      if (rsp_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
         end else begin
            txn_t e;
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata_o, e.exp_rdata);
            check("rsp_err", rsp_err_o, e.exp_err);
            check("rsp_latency", cyc - e.hs, e.lat);
            check("access_cycles", access_cnt, e.acc);
            check("rsp_bus_idle", {psel_o, penable_o, cmd_ready_o}, 3'b000);
         end
         last_rsp_cyc = cyc;
      end
   end

   // Drive one command (caller is at a falling edge); returns at the SETUP cycle.
   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                         input logic err, input bit keep);
      txn_t e;
      bit   got;
      e.wr = wr; e.addr = addr; e.wdata = wdata; e.strb = strb;
      e.waits = waits; e.rdata = rdata; e.err = err;
`ifdef APB_MASTER_TIMEOUT_EN
      if (waits >= TMO) begin
         e.exp_err = 1'b1; e.exp_rdata = 32'h0; e.acc = TMO; e.lat = 2 + TMO;
      end else
`endif
      begin
         e.exp_err = err; e.exp_rdata = wr ? 32'h0 : rdata; e.acc = waits + 1; e.lat = 3 + waits;
      end
      cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_strb_i = strb;
      cmd_valid_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (cmd_ready_o) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         check("handshake_timeout", 0, 1);
         cmd_valid_i = 1'b0;
      end else begin
         e.hs = cyc;
         exp_q.push_back(e);
         @(negedge clk);
         if (!keep) cmd_valid_i = 1'b0;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check("rsp_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
      cmd_addr_i = 32'h0; cmd_wdata_i = 32'h0; cmd_strb_i = 4'h0;
      prdata_i = 32'h0; pready_i = 1'b0; pslverr_i = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o,
                              paddr_o, pwdata_o, pstrb_o, rsp_rdata_o}, 105'd0);
      check("ready_in_reset", cmd_ready_o, 0);
      rst_i = 1'b0;
      @(negedge clk);
      check("ready_after_reset", cmd_ready_o, 1);

      do_cmd(1'b1, 32'd1, 32'h0000_00A5, 4'hF, 0, 32'h0, 1'b0, 1'b0);
      wait_idle();
      do_cmd(1'b0, 32'd3, 32'h1234_5678, 4'hF, 2, 32'h0000_0001, 1'b0, 1'b0);
      wait_idle();
      do_cmd(1'b1, 32'd4, 32'hCAFE_0004, 4'h3, 1, 32'h0, 1'b1, 1'b0);
      wait_idle();
      do_cmd(1'b0, 32'd9, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      wait_idle();

      do_cmd(1'b1, 32'd2, 32'h5A5A_0002, 4'hC, 0, 32'h0, 1'b0, 1'b1);
      do_cmd(1'b0, 32'd5, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
      if (exp_q.size() > 0) check("b2b_gap", exp_q[0].hs - last_rsp_cyc, 1);
      wait_idle();

      for (int i = 0; i < 6; i++) begin
         do_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom,
                1'($urandom_range(0, 1)), 1'b0);
         wait_idle();
      end

      do_cmd(1'b0, 32'd6, 32'h0, 4'hF, 50, 32'h1111_2222, 1'b0, 1'b0);
      @(negedge clk);
      check("pre_reset_access", {psel_o, penable_o}, 2'b11);
      rst_i = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("abort_bus", {psel_o, penable_o, rsp_valid_o, cmd_ready_o}, 4'b0000);
      check("abort_regs", {pwrite_o, paddr_o, pstrb_o}, 37'd0);
      rst_i = 1'b0;
      repeat (4) @(negedge clk);
      check("post_abort_idle", {psel_o, cmd_ready_o}, 2'b01);

      do_cmd(1'b1, 32'd7, 32'h7777_0007, 4'h1, 1, 32'h0, 1'b0, 1'b0);
      wait_idle();

`ifdef APB_MASTER_TIMEOUT_EN
      do_cmd(1'b0, 32'd0, 32'h0, 4'hF, 1000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      wait_idle();
      check("timeout_idle", {psel_o, penable_o, cmd_ready_o}, 3'b001);
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
